// File: rtl/nco_phase_gen.sv
// Phase accumulator NCO feeding the sincos angle input, with optional linear FTW chirp.
// Outputs are registered; busy is a direct decode of the state register.
module nco_phase_gen #(
    parameter int unsigned ACC_W   = 24,
    parameter int unsigned PHASE_W = 10
) (
    input  logic               clk,
    input  logic               areset,
    input  logic               en,
    input  logic               start,
    input  logic               stop,
    input  logic               sync_clr,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [ACC_W-1:0]   cfg_data,
    input  logic               chirp_en,
    output logic [PHASE_W-1:0] a,
    output logic               a_valid,
    output logic               wrap,
    output logic               chirp_done,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHIRP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   base_q, base_d;
    logic [ACC_W-1:0]   step_q, step_d;
    logic [ACC_W-1:0]   limit_q, limit_d;
    logic [ACC_W-1:0]   cur_q, cur_d;
    logic [PHASE_W-1:0] poff_q, poff_d;
    logic [PHASE_W-1:0] a_q, a_d;
    logic               valid_q, valid_d;
    logic               wrap_q, wrap_d;
    logic               done_q, done_d;

    logic               step_en;
    logic               entering;
    logic               in_run;
    logic               in_chirp;
    logic               wr_base;
    logic [ACC_W-1:0]   ftw_eff;
    logic [ACC_W:0]     acc_sum;
    logic [ACC_W:0]     ramp_sum;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (start && !stop) state_d = chirp_en ? CHIRP : RUN;
            RUN, CHIRP: if (stop) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // A stop edge takes no sample step, so acc and a hold through it.
    always_comb begin
        busy     = (state_q != IDLE);
        in_run   = (state_q == RUN);
        in_chirp = (state_q == CHIRP);
        step_en  = busy && en && !stop;
        entering = (state_q == IDLE) && (state_d != IDLE);
    end

    always_comb begin
        base_d  = base_q;
        step_d  = step_q;
        limit_d = limit_q;
        poff_d  = poff_q;
        acc_d   = acc_q;
        cur_d   = cur_q;
        a_d     = a_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        done_d  = 1'b0;

        wr_base  = cfg_we && (cfg_addr == 2'd0);
        ftw_eff  = (in_run && wr_base) ? cfg_data : cur_q;
        acc_sum  = {1'b0, acc_q} + {1'b0, ftw_eff};
        ramp_sum = {1'b0, cur_q} + {1'b0, step_q};

        if (cfg_we) begin
            case (cfg_addr)
                2'd0:    base_d  = cfg_data;
                2'd1:    step_d  = cfg_data;
                2'd2:    limit_d = cfg_data;
                default: poff_d  = cfg_data[PHASE_W-1:0];
            endcase
        end

        if (entering) begin
            cur_d = wr_base ? cfg_data : base_q;
        end else if (in_run && wr_base) begin
            cur_d = cfg_data;
        end

        if (step_en) begin
            a_d     = acc_q[ACC_W-1 -: PHASE_W] + poff_q;
            acc_d   = acc_sum[ACC_W-1:0];
            wrap_d  = acc_sum[ACC_W];
            valid_d = 1'b1;
            // Ramp reload uses the pre-write base, so a same-edge base write cannot disturb it.
            if (in_chirp) begin
                if (ramp_sum > {1'b0, limit_q}) begin
                    cur_d  = base_q;
                    done_d = 1'b1;
                end else begin
                    cur_d = ramp_sum[ACC_W-1:0];
                end
            end
        end

        if (sync_clr) begin
            acc_d  = '0;
            wrap_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            acc_q   <= '0;
            base_q  <= '0;
            step_q  <= '0;
            limit_q <= '0;
            cur_q   <= '0;
            poff_q  <= '0;
            a_q     <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            base_q  <= base_d;
            step_q  <= step_d;
            limit_q <= limit_d;
            cur_q   <= cur_d;
            poff_q  <= poff_d;
            a_q     <= a_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign a          = a_q;
    assign a_valid    = valid_q;
    assign wrap       = wrap_q;
    assign chirp_done = done_q;

endmodule
